sv_input_streamer: RTL
======================

# sv_input_streamer

Reads int8 activations from a packed 32-bit BRAM (four bytes per word, little-endian lanes) and emits them one per beat on an AXI-Stream master, walking a rectangular tile in row-major order. It sits upstream of the MAC array: the reader counterpart to the output storage block, which writes MAC results into the same BRAM word format. One word fetch serves every consecutive tile byte in that word.

## Interface
- DATA_WIDTH, 32: M_AXIS_TDATA width; byte is sign-extended into it.
- BRAM_DATA_WIDTH, 32: BRAM word width; fixed at 32 for this block.
- ADDR_WIDTH, 32: byte-address and stride width.
- DIM_WIDTH, 8: tile width/height counter width.
- C_TID_WIDTH, 1: M_AXIS_TID width.
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle load request; sampled only in IDLE or DONE.
- initial_offset  in  ADDR_WIDTH  byte address of tile element (0,0).
- row_stride  in  ADDR_WIDTH  byte distance between tile rows.
- tile_w, tile_h  in  DIM_WIDTH each  tile dimensions in elements.
- stream_id  in  C_TID_WIDTH  value driven on TID for the whole load.
- M_AXIS_TVALID, M_AXIS_TLAST  out  1 each.
- M_AXIS_TDATA  out  DATA_WIDTH.
- M_AXIS_TID  out  C_TID_WIDTH.
- M_AXIS_TREADY  in  1.
- BRAM_addr  out  32  word-aligned: {byte_addr[31:2], 2'b00}.
- BRAM_din  out  BRAM_DATA_WIDTH  tied 0.
- BRAM_dout  in  BRAM_DATA_WIDTH  read data, valid one cycle after BRAM_en.
- BRAM_en  out  1; BRAM_we  out  BRAM_DATA_WIDTH/8  tied 0.
- BRAM_clk, BRAM_rst  out  1 each  = clk and ~rst.
- busy  out  1  high from accepted start until DONE.
- load_complete  out  1  level; high in DONE until next accepted start.

## Operation
- Parameters latched on accepted start: row_base = byte_addr = initial_offset, col = row = 0, tid_q = stream_id.
- States: IDLE, FETCH, CAPTURE, STREAM, DONE.
- IDLE/DONE: start -> FETCH, or straight to DONE if tile_w==0 or tile_h==0 (no beats, no BRAM access).
- FETCH: BRAM_en=1 with address of byte_addr; -> CAPTURE.
- CAPTURE: word_q <= BRAM_dout; -> STREAM.
- STREAM: TVALID=1, TDATA = sign-extend(word_q byte lane byte_addr[1:0]), TID=tid_q, TLAST=1 when col==tile_w-1 and row==tile_h-1.
- On handshake (TVALID & TREADY): if last -> DONE. Else advance: col==tile_w-1 ? (col=0, row+1, row_base+=row_stride, byte_addr=row_base+row_stride) : (col+1, byte_addr+1). Next byte_addr in same word (bits [31:2] equal) -> stay STREAM; else -> FETCH.
- All address arithmetic modulo 2^ADDR_WIDTH; counters never exceed tile dims.
- start while busy ignored.

## Timing
- Reset values: TVALID 0, TLAST 0, TDATA 0, TID 0, BRAM_en 0, BRAM_addr 0, busy 0, load_complete 0, state IDLE.
- First beat valid 3 cycles after accepted start (FETCH, CAPTURE, STREAM).
- Within one word: one beat per cycle under TREADY=1; word change costs 2 bubble cycles.
- TVALID, TDATA, TLAST, TID held stable while TREADY=0; TVALID never drops without a handshake.
- load_complete rises the cycle after the last handshake; busy falls the same cycle.
- start in DONE: load_complete drops next cycle, busy rises.
- Reset asserted mid-load: all outputs to reset values immediately (asynchronously), pending beat discarded, no further BRAM access.

## Test plan
- BRAM word 0 = 0x80FF7F01, offset 0, 2x2 tile, stride 4, TREADY=1 -> beats 0x00000001, 0x0000007F, then (next word fetched) lanes of word 1; TLAST on 4th; load_complete after.
- Offset 3, tile_w=3, tile_h=1 -> three beats from word 0 lane 3, word 1 lanes 0-1; two fetches with 2-cycle bubble between beats 1 and 2.
- Random TREADY stalls on 8x4 tile, stride 16 -> exactly 32 beats, data matches byte model, outputs stable during stall, single TLAST.
- tile_w=0 start -> no TVALID, no BRAM_en, load_complete next cycle.
- rst pulled low during STREAM with TREADY=0 -> TVALID 0 at once; after release, start reloads cleanly from initial_offset.
- start while busy, and stream_id=1 -> start ignored; every beat carries TID=1.

Source files
------------

// File: rtl/sv_input_streamer.sv
// sv_input_streamer: walks a rectangular tile of int8 activations held in a
// packed 32-bit BRAM (four little-endian byte lanes per word) and emits them
// in row-major order, one sign-extended byte per AXI-Stream beat. A fetched
// word is reused for every consecutive tile byte that falls inside it.
module sv_input_streamer #(
   parameter int DATA_WIDTH      = 32,
   parameter int BRAM_DATA_WIDTH = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int DIM_WIDTH       = 8,
   parameter int C_TID_WIDTH     = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [ADDR_WIDTH-1:0]        initial_offset,
   input  logic [ADDR_WIDTH-1:0]        row_stride,
   input  logic [DIM_WIDTH-1:0]         tile_w,
   input  logic [DIM_WIDTH-1:0]         tile_h,
   input  logic [C_TID_WIDTH-1:0]       stream_id,
   output logic                         M_AXIS_TVALID,
   output logic                         M_AXIS_TLAST,
   output logic [DATA_WIDTH-1:0]        M_AXIS_TDATA,
   output logic [C_TID_WIDTH-1:0]       M_AXIS_TID,
   input  logic                         M_AXIS_TREADY,
   output logic [31:0]                  BRAM_addr,
   output logic [BRAM_DATA_WIDTH-1:0]   BRAM_din,
   input  logic [BRAM_DATA_WIDTH-1:0]   BRAM_dout,
   output logic                         BRAM_en,
   output logic [BRAM_DATA_WIDTH/8-1:0] BRAM_we,
   output logic                         BRAM_clk,
   output logic                         BRAM_rst,
   output logic                         busy,
   output logic                         load_complete
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_CAPTURE = 3'd2,
      S_STREAM  = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = DIM_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   state_t                       state_q, state_d;
   logic [ADDR_WIDTH-1:0]        byte_addr_q, byte_addr_d;
   logic [ADDR_WIDTH-1:0]        row_base_q, row_base_d;
   logic [ADDR_WIDTH-1:0]        row_stride_q, row_stride_d;
   logic [DIM_WIDTH-1:0]         col_q, col_d;
   logic [DIM_WIDTH-1:0]         row_q, row_d;
   logic [DIM_WIDTH-1:0]         tile_w_q, tile_w_d;
   logic [DIM_WIDTH-1:0]         tile_h_q, tile_h_d;
   logic [C_TID_WIDTH-1:0]       tid_q, tid_d;
   logic [BRAM_DATA_WIDTH-1:0]   word_q, word_d;

   logic                         last_beat;
   logic                         row_end;
   logic [ADDR_WIDTH-1:0]        next_addr;
   logic signed [7:0]            lane_byte;

   // Widen one int8 activation to the stream width, preserving its sign.
   function automatic logic [DATA_WIDTH-1:0] sext_byte(input logic signed [7:0] b);
      logic signed [DATA_WIDTH-1:0] w;
      w = DATA_WIDTH'(b);
      return w;
   endfunction

   // Control state: cleared asynchronously so a reset mid-load drops the beat at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         byte_addr_q  <= '0;
         row_base_q   <= '0;
         row_stride_q <= '0;
         col_q        <= '0;
         row_q        <= '0;
         tile_w_q     <= '0;
         tile_h_q     <= '0;
         tid_q        <= '0;
      end else begin
         state_q      <= state_d;
         byte_addr_q  <= byte_addr_d;
         row_base_q   <= row_base_d;
         row_stride_q <= row_stride_d;
         col_q        <= col_d;
         row_q        <= row_d;
         tile_w_q     <= tile_w_d;
         tile_h_q     <= tile_h_d;
         tid_q        <= tid_d;
      end
   end

   // Captured BRAM word; only observed while streaming, so it needs no reset.
   always_ff @(posedge clk) begin
      word_q <= word_d;
   end

   assign row_end   = (col_q == (tile_w_q - DIM_ONE));
   assign last_beat = row_end && (row_q == (tile_h_q - DIM_ONE));
   assign next_addr = row_end ? (row_base_q + row_stride_q) : (byte_addr_q + ADDR_ONE);
   assign lane_byte = word_q[{byte_addr_q[1:0], 3'b000} +: 8];

   // Next-state logic: load on start, fetch/capture a word, then stream its bytes.
   always_comb begin
      state_d      = state_q;
      byte_addr_d  = byte_addr_q;
      row_base_d   = row_base_q;
      row_stride_d = row_stride_q;
      col_d        = col_q;
      row_d        = row_q;
      tile_w_d     = tile_w_q;
      tile_h_d     = tile_h_q;
      tid_d        = tid_q;
      word_d       = word_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               byte_addr_d  = initial_offset;
               row_base_d   = initial_offset;
               row_stride_d = row_stride;
               col_d        = '0;
               row_d        = '0;
               tile_w_d     = tile_w;
               tile_h_d     = tile_h;
               tid_d        = stream_id;
               // An empty tile finishes without touching the BRAM.
               if ((tile_w == '0) || (tile_h == '0)) state_d = S_DONE;
               else                                  state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            word_d  = BRAM_dout;
            state_d = S_STREAM;
         end
         S_STREAM: begin
            if (M_AXIS_TREADY) begin
               if (last_beat) begin
                  state_d = S_DONE;
               end else begin
                  byte_addr_d = next_addr;
                  if (row_end) begin
                     col_d      = '0;
                     row_d      = row_q + DIM_ONE;
                     row_base_d = next_addr;
                  end else begin
                     col_d = col_q + DIM_ONE;
                  end
                  // Reuse the held word while the walk stays inside it.
                  if (next_addr[ADDR_WIDTH-1:2] != byte_addr_q[ADDR_WIDTH-1:2]) state_d = S_FETCH;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign M_AXIS_TVALID = (state_q == S_STREAM);
   assign M_AXIS_TLAST  = (state_q == S_STREAM) && last_beat;
   assign M_AXIS_TDATA  = (state_q == S_STREAM) ? sext_byte(lane_byte) : '0;
   assign M_AXIS_TID    = tid_q;

   assign BRAM_en   = (state_q == S_FETCH);
   assign BRAM_addr = 32'({byte_addr_q[ADDR_WIDTH-1:2], 2'b00});
   assign BRAM_din  = '0;
   assign BRAM_we   = '0;
   assign BRAM_clk  = clk;
   assign BRAM_rst  = ~rst;

   assign busy          = (state_q == S_FETCH) || (state_q == S_CAPTURE) || (state_q == S_STREAM);
   assign load_complete = (state_q == S_DONE);

endmodule
